spi_rx_deser: RTL and testbench

- Serial-to-parallel receiver for the codec serial link.
- Acts as bus master: generates Sck and Cs_n, shifts in Sdi MSB-first, and presents a WIDTH-bit word on a valid/ready output.
- Receive-side counterpart to the 9-bit load/shift-left transmit register on the same link.
- Sits between the codec serial pins and the control FSM that reads status and data words.

---
 rtl/spi_rx_deser_pkg.sv | 30 +++
 rtl/spi_rx_deser_if.sv | 30 +++
 rtl/spi_rx_deser_shift_in_reg.sv | 35 +++
 rtl/spi_rx_deser.sv | 165 ++++++++++++++++
 tb/tb_spi_rx_deser.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_rx_deser_pkg.sv
// -----------------------------------------------------------------------------
// spi_rx_pkg
//   Shared types and sizing helpers for the codec serial-link receiver.
//   - rx_state_t : receiver FSM states
//   - DEF_*      : default word width / Sck divider
//   - *_cnt_w    : counter widths derived from the module parameters
// -----------------------------------------------------------------------------
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCK_LO = 2'd1,
        SCK_HI = 2'd2,
        TAIL   = 2'd3
    } rx_state_t;

    localparam int DEF_WIDTH   = 9;
    localparam int DEF_CLK_DIV = 4;

    // Divider counter must hold CLK_DIV-1; one spare bit keeps CLK_DIV=1 legal.
    function automatic int div_cnt_w(input int clk_div);
        return $clog2(clk_div) + 1;
    endfunction

    // Bit counter must hold WIDTH-1.
    function automatic int bit_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/spi_rx_deser_if.sv
// -----------------------------------------------------------------------------
// spi_rx_deser_if
//   Parallel word hand-off between the serial receiver and its consumer.
//   Data_Out : received word (receiver -> consumer)
//   Valid    : Data_Out holds an unconsumed word (receiver -> consumer)
//   Ready    : consumer accepts Data_Out when Valid && Ready
//   master modport: the receiver side; slave modport: the consumer side.
// -----------------------------------------------------------------------------
interface spi_rx_deser_if
    import spi_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] Data_Out;
    logic             Valid;
    logic             Ready;

    modport master (
        output Data_Out,
        output Valid,
        input  Ready
    );

    modport slave (
        input  Data_Out,
        input  Valid,
        output Ready
    );

endinterface

// File: rtl/spi_rx_deser_shift_in_reg.sv
// -----------------------------------------------------------------------------
// shift_in_reg
//   WIDTH-bit shift-left register; new bits enter at the LSB so a word sent
//   MSB-first ends up right-justified with its MSB at Q[WIDTH-1].
//   Clk      : system clock
//   Reset_n  : asynchronous active-low reset, clears Q
//   Clr      : synchronous clear (has priority over Shift_En)
//   Shift_En : shift Sin in at the LSB this cycle
//   Sin      : serial input bit
//   Q        : register contents
// -----------------------------------------------------------------------------
module shift_in_reg
    import spi_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clr,
    input  logic             Shift_En,
    input  logic             Sin,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Q <= '0;
        end else if (Clr) begin
            Q <= '0;
        end else if (Shift_En) begin
            Q <= {Q[WIDTH-2:0], Sin};
        end
    end

endmodule

// File: rtl/spi_rx_deser.sv
// -----------------------------------------------------------------------------
// spi_rx_deser
//   Serial-to-parallel receiver for the codec serial link. Acts as bus master:
//   generates Sck (mode 0, idles low) and Cs_n, shifts Sdi in MSB-first on the
//   Sck rising edge and presents each WIDTH-bit word on a valid/ready port.
//
//   Parameters
//     WIDTH   : bits per word (2..16)
//     CLK_DIV : Clk cycles per Sck half-period (>= 1)
//   Ports
//     Clk      : system clock, all logic on posedge
//     Reset_n  : asynchronous active-low reset
//     Start    : request one word transfer, sampled only in IDLE
//     Sdi      : serial data from codec (changes after Sck falls)
//     Sck      : serial clock, registered
//     Cs_n     : chip select, active low, registered
//     Busy     : high from the cycle after Start is accepted to word completion
//     Overrun  : sticky, a word completed while the previous one was unread
//     Clr_Ovr  : synchronous clear of Overrun (a simultaneous set wins)
//     rx       : Data_Out / Valid / Ready word hand-off (master side)
// -----------------------------------------------------------------------------
module spi_rx_deser
    import spi_rx_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Start,
    input  logic           Sdi,
    output logic           Sck,
    output logic           Cs_n,
    output logic           Busy,
    output logic           Overrun,
    input  logic           Clr_Ovr,
    spi_rx_deser_if.master rx
);

    localparam int DIV_W = div_cnt_w(CLK_DIV);
    localparam int BIT_W = bit_cnt_w(WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    rx_state_t        state;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    logic div_done;
    logic accept;
    logic shift_en;
    logic complete;
    logic deliver;

    always_comb begin
        div_done = (div_cnt == DIV_LAST);
        accept   = (state == IDLE) && Start;
        // Sample Sdi on the edge that raises Sck; the codec moved it half a
        // period earlier, on the falling edge.
        shift_en = (state == SCK_LO) && div_done;
        complete = (state == TAIL) && div_done;
        // A completing word is taken if the slot is empty or is being read
        // on this same edge; otherwise it is dropped.
        deliver  = complete && (!valid_q || rx.Ready);
    end

    shift_in_reg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Clr      (accept),
        .Shift_En (shift_en),
        .Sin      (Sdi),
        .Q        (shreg)
    );

    // Sequencer: each phase lasts CLK_DIV cycles, div_cnt restarts at every
    // phase change.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            Sck     <= 1'b0;
            Cs_n    <= 1'b1;
            Busy    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        Cs_n    <= 1'b0;
                        Busy    <= 1'b1;
                        Sck     <= 1'b0;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= SCK_LO;
                    end
                end
                SCK_LO: begin
                    if (div_done) begin
                        Sck     <= 1'b1;
                        div_cnt <= '0;
                        state   <= SCK_HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SCK_HI: begin
                    if (div_done) begin
                        Sck     <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        state   <= (bit_cnt == BIT_LAST) ? TAIL : SCK_LO;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                TAIL: begin
                    if (div_done) begin
                        Cs_n    <= 1'b1;
                        Busy    <= 1'b0;
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output word, handshake and overrun flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            if (deliver) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && rx.Ready) begin
                valid_q <= 1'b0;
            end

            if (complete && !deliver) begin
                Overrun <= 1'b1;
            end else if (Clr_Ovr) begin
                Overrun <= 1'b0;
            end
        end
    end

    assign rx.Data_Out = data_q;
    assign rx.Valid    = valid_q;

endmodule

// File: tb/tb_spi_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_deser
//   Bench for spi_rx_deser: a default instance (WIDTH=9, CLK_DIV=4) and a fast
//   instance (CLK_DIV=1), each fed by a behavioural codec that drives Sdi
//   MSB-first off the Sck falling edge. Delivered words are checked against a
//   queue of expected words filled when each transfer is launched.
// -----------------------------------------------------------------------------
module tb_spi_rx_deser;

    localparam int W     = 9;
    localparam int CD_A  = 4;
    localparam int CD_B  = 1;
    localparam int CYC_A = CD_A * (2 * W + 1);   // 76
    localparam int CYC_B = CD_B * (2 * W + 1);   // 19

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- DUT A (defaults) ----------------
    logic start_a, sdi_a, sck_a, cs_n_a, busy_a, ovr_a, clr_a;
    spi_rx_deser_if #(.WIDTH(W)) bus_a ();

    spi_rx_deser #(.WIDTH(W), .CLK_DIV(CD_A)) u_dut_a (
        .Clk     (clk),
        .Reset_n (rst_n),
        .Start   (start_a),
        .Sdi     (sdi_a),
        .Sck     (sck_a),
        .Cs_n    (cs_n_a),
        .Busy    (busy_a),
        .Overrun (ovr_a),
        .Clr_Ovr (clr_a),
        .rx      (bus_a.master)
    );

    // ---------------- DUT B (CLK_DIV=1) ----------------
    logic start_b, sdi_b, sck_b, cs_n_b, busy_b, ovr_b, clr_b;
    spi_rx_deser_if #(.WIDTH(W)) bus_b ();

    spi_rx_deser #(.WIDTH(W), .CLK_DIV(CD_B)) u_dut_b (
        .Clk     (clk),
        .Reset_n (rst_n),
        .Start   (start_b),
        .Sdi     (sdi_b),
        .Sck     (sck_b),
        .Cs_n    (cs_n_b),
        .Busy    (busy_b),
        .Overrun (ovr_b),
        .Clr_Ovr (clr_b),
        .rx      (bus_b.master)
    );

    // ---------------- codec models ----------------
    logic [W-1:0] slv_q_a[$];
    logic [W-1:0] slv_word_a;
    int           slv_idx_a;
    int           xfer_cnt_a = 0;

    always @(negedge cs_n_a) begin
        xfer_cnt_a++;
        slv_word_a = (slv_q_a.size() > 0) ? slv_q_a.pop_front() : '0;
        slv_idx_a  = W - 1;
        sdi_a      = slv_word_a[W-1];
    end

    always @(negedge sck_a) begin
        if (cs_n_a === 1'b0) begin
            slv_idx_a--;
            if (slv_idx_a >= 0) sdi_a = slv_word_a[slv_idx_a];
        end
    end

    logic [W-1:0] slv_q_b[$];
    logic [W-1:0] slv_word_b;
    int           slv_idx_b;

    always @(negedge cs_n_b) begin
        slv_word_b = (slv_q_b.size() > 0) ? slv_q_b.pop_front() : '0;
        slv_idx_b  = W - 1;
        sdi_b      = slv_word_b[W-1];
    end

    always @(negedge sck_b) begin
        if (cs_n_b === 1'b0) begin
            slv_idx_b--;
            if (slv_idx_b >= 0) sdi_b = slv_word_b[slv_idx_b];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: every word read through the handshake must be the oldest
    // word the bench expects to be delivered.
    logic [W-1:0] exp_q_a[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_a.Valid === 1'b1 && bus_a.Ready === 1'b1) begin
            if (exp_q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_word: got 0x%0h, required no word", bus_a.Data_Out);
            end else begin
                check("sb_word", 32'(bus_a.Data_Out), 32'(exp_q_a.pop_front()));
            end
        end
    end

    // Launch one transfer on DUT A; returns 1 ns after the accepting edge E0.
    task automatic start_only_a(input logic [W-1:0] word, input bit deliver);
        slv_q_a.push_back(word);
        if (deliver) exp_q_a.push_back(word);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    // Full transfer on DUT A; measures cycles from E0 to Busy falling, counts
    // Sck rising edges and Sck runs whose length is not CLK_DIV.
    task automatic xfer_a(input logic [W-1:0] word, input bit deliver,
                          output int cyc, output int rises, output int bad);
        int   run;
        logic prev;
        start_only_a(word, deliver);
        cyc   = 0;
        rises = 0;
        bad   = 0;
        run   = 1;
        prev  = sck_a;
        while (busy_a === 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (sck_a !== prev) begin
                if (run != CD_A) bad++;
                if (sck_a === 1'b1) rises++;
                run  = 1;
                prev = sck_a;
            end else begin
                run++;
            end
        end
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] exp_data;
        int           exp_cyc;
        int           exp_rises;
    } vec_t;

    vec_t tbl[5];

    initial begin : main
        int cyc, rises, bad, cnt0, gaps, bad_gaps, high_run, waited;
        bit seen_low;

        tbl[0] = '{9'h1A5, 9'h1A5, CYC_A, W};
        tbl[1] = '{9'h000, 9'h000, CYC_A, W};
        tbl[2] = '{9'h1FF, 9'h1FF, CYC_A, W};
        tbl[3] = '{9'h0AA, 9'h0AA, CYC_A, W};
        tbl[4] = '{9'h101, 9'h101, CYC_A, W};

        rst_n       = 1'b0;
        start_a     = 1'b0;
        sdi_a       = 1'b0;
        clr_a       = 1'b0;
        bus_a.Ready = 1'b0;
        start_b     = 1'b0;
        sdi_b       = 1'b0;
        clr_b       = 1'b0;
        bus_b.Ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sck",   32'(sck_a),          32'h0);
        check("rst_cs_n",  32'(cs_n_a),         32'h1);
        check("rst_busy",  32'(busy_a),         32'h0);
        check("rst_valid", 32'(bus_a.Valid),    32'h0);
        check("rst_ovr",   32'(ovr_a),          32'h0);
        check("rst_data",  32'(bus_a.Data_Out), 32'h0);
        check("rst_b_cs_n", 32'(cs_n_b),        32'h1);
        rst_n = 1'b1;

        // Table-driven transfers with Ready held high
        bus_a.Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            xfer_a(tbl[i].word, 1'b1, cyc, rises, bad);
            check("tbl_cycles", 32'(cyc),            32'(tbl[i].exp_cyc));
            check("tbl_rises",  32'(rises),          32'(tbl[i].exp_rises));
            check("tbl_sck_hl", 32'(bad),            32'h0);
            check("tbl_valid",  32'(bus_a.Valid),    32'h1);
            check("tbl_data",   32'(bus_a.Data_Out), 32'(tbl[i].exp_data));
        end
        @(posedge clk); #1;
        check("tbl_valid_drop", 32'(bus_a.Valid), 32'h0);

        // Overrun: second word dropped while the first is unread; Clr_Ovr
        // held across the dropping edge loses to the set.
        bus_a.Ready = 1'b0;
        xfer_a(9'h0F0, 1'b1, cyc, rises, bad);
        check("ovr_first_data", 32'(bus_a.Data_Out), 32'h0F0);
        clr_a = 1'b1;
        xfer_a(9'h10F, 1'b0, cyc, rises, bad);
        check("ovr_set_wins", 32'(ovr_a),          32'h1);
        check("ovr_hold",     32'(bus_a.Data_Out), 32'h0F0);
        check("ovr_valid",    32'(bus_a.Valid),    32'h1);
        @(posedge clk); #1 clr_a = 1'b0;
        check("ovr_cleared",  32'(ovr_a),          32'h0);
        bus_a.Ready = 1'b1;
        @(posedge clk); #1 bus_a.Ready = 1'b0;
        check("ovr_read_valid", 32'(bus_a.Valid), 32'h0);

        // Ready on the exact completion edge while an old word is held
        xfer_a(9'h0AA, 1'b1, cyc, rises, bad);
        check("roc_hold", 32'(bus_a.Data_Out), 32'h0AA);
        start_only_a(9'h155, 1'b1);
        repeat (CYC_A - 1) @(posedge clk);
        #1;
        check("roc_busy_pre", 32'(busy_a), 32'h1);
        bus_a.Ready = 1'b1;
        @(posedge clk); #1 bus_a.Ready = 1'b0;
        check("roc_busy_post", 32'(busy_a),         32'h0);
        check("roc_valid",     32'(bus_a.Valid),    32'h1);
        check("roc_data",      32'(bus_a.Data_Out), 32'h155);
        check("roc_ovr",       32'(ovr_a),          32'h0);

        // Asynchronous reset mid-SCK_HI of bit 4 (Valid still high from above)
        start_only_a(9'h1FF, 1'b0);
        repeat (CD_A * 9 + 1) @(posedge clk);
        #1;
        check("mid_sck_high", 32'(sck_a), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_sck",   32'(sck_a),          32'h0);
        check("arst_cs_n",  32'(cs_n_a),         32'h1);
        check("arst_busy",  32'(busy_a),         32'h0);
        check("arst_valid", 32'(bus_a.Valid),    32'h0);
        check("arst_data",  32'(bus_a.Data_Out), 32'h0);
        exp_q_a.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        bus_a.Ready = 1'b1;
        xfer_a(9'h133, 1'b1, cyc, rises, bad);
        check("post_rst_cycles", 32'(cyc),            32'(CYC_A));
        check("post_rst_data",   32'(bus_a.Data_Out), 32'h133);
        check("post_rst_rises",  32'(rises),          32'(W));

        // Start pulses during Busy are ignored, including one sampled on the
        // completion edge itself.
        cnt0 = xfer_cnt_a;
        start_only_a(9'h0C3, 1'b1);
        for (int k = 1; k <= CYC_A; k++) begin
            @(posedge clk); #1;
            start_a = (k == 5 || k == 30 || k == 60 || k == CYC_A - 1) ? 1'b1 : 1'b0;
        end
        check("pulse_busy_done", 32'(busy_a), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("pulse_xfers", 32'(xfer_cnt_a - cnt0), 32'h1);
        check("pulse_idle",  32'(busy_a),             32'h0);

        // Start held high: three words back to back, Cs_n high 1 cycle between
        for (int i = 0; i < 3; i++) begin
            slv_q_a.push_back(9'h03C + 9'(i * 9'h061));
            exp_q_a.push_back(9'h03C + 9'(i * 9'h061));
        end
        cnt0     = xfer_cnt_a;
        gaps     = 0;
        bad_gaps = 0;
        high_run = 0;
        seen_low = 1'b0;
        waited   = 0;
        @(posedge clk); #1 start_a = 1'b1;
        while ((xfer_cnt_a - cnt0) < 3 && waited < 400) begin
            @(posedge clk); #1;
            waited++;
            if (cs_n_a === 1'b1) begin
                high_run++;
            end else begin
                if (seen_low && high_run > 0) begin
                    gaps++;
                    if (high_run != 1) bad_gaps++;
                end
                high_run = 0;
                seen_low = 1'b1;
            end
        end
        start_a = 1'b0;
        waited  = 0;
        while (busy_a === 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check("b2b_xfers",    32'(xfer_cnt_a - cnt0), 32'h3);
        check("b2b_gaps",     32'(gaps),              32'h2);
        check("b2b_gap_len",  32'(bad_gaps),          32'h0);
        check("b2b_finished", 32'(busy_a),            32'h0);
        repeat (2) @(posedge clk);
        #1;

        // CLK_DIV=1 instance
        slv_q_b.push_back(9'h155);
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        cyc   = 0;
        rises = 0;
        begin
            logic prev_b;
            prev_b = sck_b;
            while (busy_b === 1'b1 && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
                if (sck_b === 1'b1 && prev_b !== 1'b1) rises++;
                prev_b = sck_b;
            end
        end
        check("fast_cycles", 32'(cyc),            32'(CYC_B));
        check("fast_rises",  32'(rises),          32'(W));
        check("fast_valid",  32'(bus_b.Valid),    32'h1);
        check("fast_data",   32'(bus_b.Data_Out), 32'h155);
        bus_b.Ready = 1'b1;
        @(posedge clk); #1 bus_b.Ready = 1'b0;
        check("fast_read", 32'(bus_b.Valid), 32'h0);

        check("sb_drained", 32'(exp_q_a.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout, required run to complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
